bcd_time_source: RTL and testbench
==================================

BCD_TIME_SOURCE -- requirements
Module: bcd_time_source

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, giving the CLOCK_50 cycles per second tick (minimum 2).
REQ-002 The block SHALL have input CLOCK_50, 1 bit, the single clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have input reset_n, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have input run, 1 bit; high lets time advance, low freezes the time and holds the prescaler.
REQ-005 The block SHALL have input load_valid, 1 bit; a write request from the HPS side.
REQ-006 The block SHALL have input load_word, 32 bits; the requested time in packed BCD.
REQ-007 The block SHALL have output load_ready, 1 bit; high when a request can be accepted.
REQ-008 The block SHALL have output load_err, 1 bit; a one-cycle pulse when a request is rejected.
REQ-009 The block SHALL have output time_word, 32 bits, registered; the current time for the display clock reader.
REQ-010 The block SHALL have output time_strobe, 1 bit; a one-cycle pulse each time time_word changes.

Function
REQ-011 The time_word format SHALL be:
- [31:24] = 0
- [23:20] hours tens, [19:16] hours units
- [15:12] minutes tens, [11:8] minutes units
- [7:4] seconds tens, [3:0] seconds units
REQ-012 The prescaler SHALL count 0..CLK_HZ-1 while run=1 and issue an internal tick on the cycle it wraps from CLK_HZ-1 to 0.
REQ-013 On a tick, seconds SHALL increment in BCD with carries: units 9->0 carries into tens; seconds tens 5->0 carries into minutes; minutes carry the same way into hours.
REQ-014 Hours SHALL wrap at 24: 23:59:59 -> 00:00:00, with a single time_strobe.
REQ-015 time_word and time_strobe SHALL update on the same edge that the tick occurs (zero added latency).
REQ-016 The load handshake SHALL use a two-state FSM:
- IDLE: load_ready=1; load_valid=1 moves to CHECK, capturing load_word.
- CHECK: load_ready=0; exactly one cycle, then back to IDLE.
REQ-017 In CHECK, the captured word SHALL be valid only if all of the following hold:
- [31:24]=0
- every digit <=9
- seconds tens <=5 and minutes tens <=5
- hours value <=23
REQ-018 A valid captured word SHALL be written to time_word at the CHECK->IDLE edge, with time_strobe=1 and the prescaler cleared to 0.
REQ-019 An invalid captured word SHALL leave time_word unchanged, pulse load_err for that cycle, and leave the prescaler unaffected.
REQ-020 If a tick coincides with the CHECK cycle of a valid load, the load SHALL win and that tick SHALL be discarded.
REQ-021 If a tick coincides with the CHECK cycle of an invalid load, the tick SHALL apply normally.
REQ-022 load_valid in CHECK SHALL be ignored; a held load_valid is re-accepted in the next IDLE cycle.
REQ-023 A load SHALL be accepted regardless of run; run=0 keeps the loaded time frozen.
REQ-024 Deasserting run SHALL hold the prescaler value, and reasserting it SHALL resume counting from that value.

Reset
REQ-025 reset_n=0 SHALL asynchronously force:
- time_word=32'h00000000, prescaler=0
- FSM=IDLE, load_ready=1
- load_err=0, time_strobe=0
REQ-026 Reset asserted mid-CHECK SHALL abort the load, with no write and no load_err.
REQ-027 After reset_n rises, the first tick with run=1 SHALL occur CLK_HZ cycles later.

Verification (CLK_HZ=10)
REQ-028 Reset, run=1, 25 cycles -> time_word=00000002 after cycles 10 and 20, two time_strobe pulses.
REQ-029 Load 00235958, run=1, 20 cycles -> 00235959, then 00000000, one strobe each.
REQ-030 Load 00000960 (seconds 60) -> load_err pulses once, time_word unchanged, load_ready low exactly one cycle.
REQ-031 Load 00240000 and load 01000000 -> two load_err pulses, time_word unchanged.
REQ-032 Load 00120000 issued on a tick cycle -> time_word=00120000, next strobe 10 cycles later (00120001).
REQ-033 run=0 for 50 cycles -> no strobes, time_word frozen; reset_n pulsed low during CHECK -> time_word=0, no load_err.

Source files
------------

// File: rtl/bcd_time_source.sv
// Time-of-day source: prescaled one-second tick driving a packed-BCD hh:mm:ss
// register, with a validated load port for setting the time from the HPS.
module bcd_time_source #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        run,
    input  logic        load_valid,
    input  logic [31:0] load_word,
    output logic        load_ready,
    output logic        load_err,
    output logic [31:0] time_word,
    output logic        time_strobe
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_cap, w_cap_nxt;
    logic          r_load_ready, w_load_ready_nxt;
    logic          r_load_err, w_load_err_nxt;
    logic          w_load_ok;
    logic          w_valid;

    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [23:0]   r_time, w_time_nxt, w_time_inc;
    logic          r_strobe, w_strobe_nxt;
    logic          w_tick;

    // Legality of the captured word as a 24-hour BCD time.
    always_comb begin
        w_valid = (r_cap[31:24] == 8'h00) && (r_cap[7:4] <= 4'd5) &&
                  (r_cap[15:12] <= 4'd5) && (r_cap[23:20] <= 4'd2);
        for (int i = 0; i < 6; i++) begin
            if (r_cap[i*4 +: 4] > 4'd9) w_valid = 1'b0;
        end
        if ((r_cap[23:20] == 4'd2) && (r_cap[19:16] > 4'd3)) w_valid = 1'b0;
    end

    // One-second BCD increment with ripple carries and 24-hour wrap.
    always_comb begin
        w_time_inc = r_time;
        if (r_time[3:0] != 4'd9) begin
            w_time_inc[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_time_inc[3:0] = 4'd0;
            if (r_time[7:4] != 4'd5) begin
                w_time_inc[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_time_inc[7:4] = 4'd0;
                if (r_time[11:8] != 4'd9) begin
                    w_time_inc[11:8] = r_time[11:8] + 4'd1;
                end else begin
                    w_time_inc[11:8] = 4'd0;
                    if (r_time[15:12] != 4'd5) begin
                        w_time_inc[15:12] = r_time[15:12] + 4'd1;
                    end else begin
                        w_time_inc[15:12] = 4'd0;
                        if (r_time[23:16] == 8'h23) begin
                            w_time_inc[23:16] = 8'h00;
                        end else if (r_time[19:16] == 4'd9) begin
                            w_time_inc[19:16] = 4'd0;
                            w_time_inc[23:20] = r_time[23:20] + 4'd1;
                        end else begin
                            w_time_inc[19:16] = r_time[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Load handshake next-state and outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_cap_nxt      = r_cap;
        w_load_ok      = 1'b0;
        w_load_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_state_nxt = S_CHECK;
                    w_cap_nxt   = load_word;
                end
            end
            S_CHECK: begin
                w_state_nxt    = S_IDLE;
                w_load_ok      = w_valid;
                w_load_err_nxt = ~w_valid;
            end
        endcase
        w_load_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // A valid load overrides a coincident tick and restarts the prescaler.
    always_comb begin
        w_tick       = run && (r_presc == P_LAST);
        w_presc_nxt  = r_presc;
        w_time_nxt   = r_time;
        w_strobe_nxt = 1'b0;
        if (run) w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        if (w_load_ok) begin
            w_presc_nxt  = '0;
            w_time_nxt   = r_cap[23:0];
            w_strobe_nxt = 1'b1;
        end else if (w_tick) begin
            w_time_nxt   = w_time_inc;
            w_strobe_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cap        <= '0;
            r_load_ready <= 1'b1;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cap        <= w_cap_nxt;
            r_load_ready <= w_load_ready_nxt;
            r_load_err   <= w_load_err_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_presc  <= '0;
            r_time   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_presc  <= w_presc_nxt;
            r_time   <= w_time_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign load_ready  = r_load_ready;
    assign load_err    = r_load_err;
    assign time_word   = {8'h00, r_time};
    assign time_strobe = r_strobe;

endmodule

// File: tb/tb_bcd_time_source.sv
// Bench for bcd_time_source: directed scenarios plus randomized traffic checked
// against a seconds-of-day reference model.
module tb_bcd_time_source;

    localparam int HZ = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_word = 32'h0;
    logic        load_ready;
    logic        load_err;
    logic [31:0] time_word;
    logic        time_strobe;

    bcd_time_source #(.CLK_HZ(HZ)) dut (
        .CLOCK_50   (clk),
        .reset_n    (reset_n),
        .run        (run),
        .load_valid (load_valid),
        .load_word  (load_word),
        .load_ready (load_ready),
        .load_err   (load_err),
        .time_word  (time_word),
        .time_strobe(time_strobe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state: time as seconds since midnight
    int          m_secs, m_presc;
    bit          m_check, m_err, m_strobe;
    logic [31:0] m_cap;

    int n_strobe, n_err, n_busy, cyc_no;
    int strobe_at[$];

    function automatic bit word_ok(input logic [31:0] w);
        int d[6];
        if (w[31:24] != 8'h00) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(w[4*i +: 4]);
            if (d[i] > 9) return 1'b0;
        end
        return (d[1] <= 5) && (d[3] <= 5) && ((d[5] * 10 + d[4]) <= 23);
    endfunction

    function automatic int word_secs(input logic [31:0] w);
        int d[6];
        for (int i = 0; i < 6; i++) d[i] = int'(w[4*i +: 4]);
        return (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    endfunction

    function automatic logic [31:0] secs_word(input int s);
        int h, m, c;
        h = s / 3600;
        m = (s / 60) % 60;
        c = s % 60;
        return {8'h00, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_presc = 0; m_check = 1'b0; m_err = 1'b0; m_strobe = 1'b0; m_cap = 32'h0;
    endtask

    task automatic model_step();
        bit tick;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tick = run && (m_presc == HZ - 1);
        m_strobe = 1'b0;
        m_err = 1'b0;
        if (run) m_presc = (m_presc + 1) % HZ;
        if (m_check) begin
            if (word_ok(m_cap)) begin
                m_secs = word_secs(m_cap);
                m_presc = 0;
                m_strobe = 1'b1;
                tick = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_check = 1'b0;
        end else if (load_valid) begin
            m_check = 1'b1;
            m_cap = load_word;
        end
        if (tick) begin
            m_secs = (m_secs + 1) % 86400;
            m_strobe = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_no++;
        if (time_strobe) begin
            n_strobe++;
            strobe_at.push_back(cyc_no);
        end
        if (load_err) n_err++;
        if (!load_ready) n_busy++;
    endtask

    task automatic clear_counts();
        n_strobe = 0; n_err = 0; n_busy = 0; cyc_no = 0;
        strobe_at.delete();
    endtask

    task automatic do_load(input logic [31:0] w);
        load_word = w;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; load_valid = 1'b0;
        model_reset();
        repeat (3) cyc();
        reset_n = 1'b1;
        total++; if (time_word !== 32'h0) begin bad++; $display("FAIL reset_time got=%h exp=%h", time_word, 32'h0); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", load_err); end
        total++; if (time_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", time_strobe); end
    endtask

    task automatic test_count();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        run = 1'b1;
        clear_counts();
        repeat (25) cyc();
        total++; if (time_word !== 32'h00000002) begin bad++; $display("FAIL count_time got=%h exp=%h", time_word, 32'h2); end
        total++; if (n_strobe !== 2) begin bad++; $display("FAIL count_strobes got=%0d exp=2", n_strobe); end
        total++; if (strobe_at.size() < 1 || strobe_at[0] !== 10) begin bad++; $display("FAIL count_first_tick got=%0d exp=10", strobe_at.size() > 0 ? strobe_at[0] : -1); end
        total++; if (strobe_at.size() < 2 || strobe_at[1] !== 20) begin bad++; $display("FAIL count_second_tick got=%0d exp=20", strobe_at.size() > 1 ? strobe_at[1] : -1); end
    endtask

    task automatic test_wrap();
        run = 1'b1;
        do_load(32'h00235958);
        total++; if (time_word !== 32'h00235958) begin bad++; $display("FAIL wrap_load got=%h exp=%h", time_word, 32'h00235958); end
        total++; if (time_strobe !== 1'b1) begin bad++; $display("FAIL wrap_load_strobe got=%b exp=1", time_strobe); end
        clear_counts();
        repeat (10) cyc();
        total++; if (time_word !== 32'h00235959) begin bad++; $display("FAIL wrap_59 got=%h exp=%h", time_word, 32'h00235959); end
        total++; if (n_strobe !== 1) begin bad++; $display("FAIL wrap_59_strobes got=%0d exp=1", n_strobe); end
        repeat (10) cyc();
        total++; if (time_word !== 32'h00000000) begin bad++; $display("FAIL wrap_midnight got=%h exp=%h", time_word, 32'h0); end
        total++; if (n_strobe !== 2) begin bad++; $display("FAIL wrap_strobes got=%0d exp=2", n_strobe); end
    endtask

    task automatic test_invalid();
        run = 1'b0;
        clear_counts();
        do_load(32'h00000960);
        cyc();
        total++; if (n_err !== 1) begin bad++; $display("FAIL bad_secs_err got=%0d exp=1", n_err); end
        total++; if (n_busy !== 1) begin bad++; $display("FAIL bad_secs_busy got=%0d exp=1", n_busy); end
        total++; if (time_word !== 32'h0) begin bad++; $display("FAIL bad_secs_time got=%h exp=%h", time_word, 32'h0); end
        clear_counts();
        do_load(32'h00240000);
        do_load(32'h01000000);
        cyc();
        total++; if (n_err !== 2) begin bad++; $display("FAIL bad_hours_err got=%0d exp=2", n_err); end
        total++; if (n_strobe !== 0) begin bad++; $display("FAIL bad_hours_strobe got=%0d exp=0", n_strobe); end
        total++; if (time_word !== 32'h0) begin bad++; $display("FAIL bad_hours_time got=%h exp=%h", time_word, 32'h0); end
    endtask

    task automatic test_load_on_tick();
        run = 1'b1;
        for (int k = 0; k < 20 && m_presc != HZ - 2; k++) cyc();
        total++; if (m_presc != HZ - 2) begin bad++; $display("FAIL tick_align got=%0d exp=%0d", m_presc, HZ - 2); end
        do_load(32'h00120000);
        total++; if (time_word !== 32'h00120000) begin bad++; $display("FAIL tick_load got=%h exp=%h", time_word, 32'h00120000); end
        clear_counts();
        repeat (10) cyc();
        total++; if (time_word !== 32'h00120001) begin bad++; $display("FAIL tick_next got=%h exp=%h", time_word, 32'h00120001); end
        total++; if (n_strobe !== 1 || strobe_at[0] !== 10) begin bad++; $display("FAIL tick_next_at got=%0d exp=10", n_strobe > 0 ? strobe_at[0] : -1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2;
        w1 = secs_word(int'($urandom_range(0, 86399)));
        w2 = secs_word(int'($urandom_range(0, 86399)));
        run = 1'b0;
        clear_counts();
        load_valid = 1'b1;
        load_word = w1;
        cyc();
        load_word = w2;
        repeat (3) cyc();
        load_valid = 1'b0;
        total++; if (n_busy !== 2) begin bad++; $display("FAIL b2b_busy got=%0d exp=2", n_busy); end
        total++; if (n_strobe !== 2) begin bad++; $display("FAIL b2b_strobes got=%0d exp=2", n_strobe); end
        total++; if (time_word !== w2) begin bad++; $display("FAIL b2b_time got=%h exp=%h", time_word, w2); end
    endtask

    task automatic test_freeze();
        logic [31:0] held;
        held = secs_word(m_secs);
        run = 1'b0;
        clear_counts();
        repeat (50) cyc();
        total++; if (n_strobe !== 0) begin bad++; $display("FAIL freeze_strobes got=%0d exp=0", n_strobe); end
        total++; if (time_word !== held) begin bad++; $display("FAIL freeze_time got=%h exp=%h", time_word, held); end
        load_word = 32'h00101010;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        model_reset();
        total++; if (time_word !== 32'h0) begin bad++; $display("FAIL abort_time got=%h exp=%h", time_word, 32'h0); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", load_ready); end
        cyc();
        reset_n = 1'b1;
        clear_counts();
        repeat (4) cyc();
        total++; if (n_err !== 0) begin bad++; $display("FAIL abort_err got=%0d exp=0", n_err); end
        total++; if (time_word !== 32'h0) begin bad++; $display("FAIL abort_after got=%h exp=%h", time_word, 32'h0); end
    endtask

    task automatic test_random();
        logic [31:0] exp_t;
        for (int n = 0; n < 600; n++) begin
            run = ($urandom_range(0, 9) != 0);
            load_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0)
                load_word = secs_word(int'($urandom_range(86340, 86399)) - int'($urandom_range(0, 1)) * int'($urandom_range(0, 86000)));
            else
                load_word = {($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 24'($urandom)};
            cyc();
            exp_t = secs_word(m_secs);
            total++; if (time_word !== exp_t) begin bad++; $display("FAIL rnd_time n=%0d got=%h exp=%h", n, time_word, exp_t); end
            total++; if (time_strobe !== m_strobe) begin bad++; $display("FAIL rnd_strobe n=%0d got=%b exp=%b", n, time_strobe, m_strobe); end
            total++; if (load_err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, load_err, m_err); end
            total++; if (load_ready !== !m_check) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, load_ready, !m_check); end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_counts();
        @(negedge clk);
        test_reset();
        test_count();
        test_wrap();
        test_invalid();
        test_load_on_tick();
        test_back_to_back();
        test_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
